// File: rtl/vga_timing_out.sv
// vga_timing_out: raster counters plus registered, blanked RGB/HSYNC/VSYNC output stage.
// Revision 1.0
`default_nettype none

module vga_timing_out #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] color,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic [7:0] frame,
  output logic       display_on,
  output logic       hsync,
  output logic       vsync,
  output logic [5:0] rgb
);

  localparam logic [9:0] H_MAX    = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_MAX    = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic [7:0] frame_q, frame_d;
  logic [5:0] rgb_q, rgb_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       h_wrap, v_wrap, vis;

  always_comb begin
    h_wrap  = (h_q == H_MAX);
    v_wrap  = (v_q == V_MAX);
    h_d     = h_wrap ? 10'd0 : h_q + 10'd1;
    v_d     = v_q;
    frame_d = frame_q;
    if (h_wrap) begin
      v_d = v_wrap ? 10'd0 : v_q + 10'd1;
      if (v_wrap) begin
        frame_d = frame_q + 8'd1;
      end
    end
    vis     = (h_q < H_VIS) && (v_q < V_VIS);
    rgb_d   = vis ? color : 6'd0;
    // Sync is active-low, so the register holds the inverted window decode.
    hsync_d = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
    vsync_d = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q     <= 10'd0;
      v_q     <= 10'd0;
      frame_q <= 8'd0;
      rgb_q   <= 6'd0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      frame_q <= frame_d;
      rgb_q   <= rgb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign pix_x      = h_q;
  assign pix_y      = v_q;
  assign frame      = frame_q;
  assign display_on = vis;
  assign rgb        = rgb_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_out.sv
// tb_vga_timing_out: directed bench on a scaled raster (20x10 totals) so 256 frames fit a short run.
// Revision 1.0
`default_nettype none

module tb_vga_timing_out;

  localparam int HD = 12, HF = 2, HS = 3, HB = 3;
  localparam int VD = 6,  VF = 1, VS = 2, VB = 1;
  localparam int HT = HD + HF + HS + HB;  // 20
  localparam int VT = VD + VF + VS + VB;  // 10
  localparam int FT = HT * VT;            // 200

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] color;
  logic [9:0] pix_x, pix_y;
  logic [7:0] frame;
  logic       display_on, hsync, vsync;
  logic [5:0] rgb;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  vga_timing_out #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) u_dut (
    .clk(clk), .reset(reset), .color(color),
    .pix_x(pix_x), .pix_y(pix_y), .frame(frame), .display_on(display_on),
    .hsync(hsync), .vsync(vsync), .rgb(rgb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: t = clocks since reset release; position is t decomposed over line/frame periods,
  // registered outputs describe position t-1 and the colour presented during it.
  int unsigned t;
  logic [5:0]  prev_color;
  always @(posedge clk or posedge reset) begin
    if (reset) t <= 0;
    else begin
      t          <= t + 1;
      prev_color <= color;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int unsigned px, py;
      logic [5:0] e_rgb;
      logic       e_hs, e_vs;
      e_rgb = 6'd0; e_hs = 1'b1; e_vs = 1'b1;
      if (t > 0) begin
        px    = (t - 1) % HT;
        py    = ((t - 1) / HT) % VT;
        e_rgb = (px < HD && py < VD) ? prev_color : 6'd0;
        e_hs  = !(px >= HD + HF && px < HD + HF + HS);
        e_vs  = !(py >= VD + VF && py < VD + VF + VS);
      end
      chk("m_pix_x", 32'(pix_x), t % HT);
      chk("m_pix_y", 32'(pix_y), (t / HT) % VT);
      chk("m_frame", 32'(frame), (t / FT) % 256);
      chk("m_display_on", 32'(display_on), 32'((t % HT) < HD && ((t / HT) % VT) < VD));
      chk("m_rgb", 32'(rgb), 32'(e_rgb));
      chk("m_hsync", 32'(hsync), 32'(e_hs));
      chk("m_vsync", 32'(vsync), 32'(e_vs));
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_pix_x"}, 32'(pix_x), 0);
    chk({tag, "_pix_y"}, 32'(pix_y), 0);
    chk({tag, "_frame"}, 32'(frame), 0);
    chk({tag, "_rgb"}, 32'(rgb), 0);
    chk({tag, "_hsync"}, 32'(hsync), 1);
    chk({tag, "_vsync"}, 32'(vsync), 1);
    chk({tag, "_display_on"}, 32'(display_on), 1);
  endtask

  initial begin
    int first_hs_low, hs_lows, first_vs_low, vs_lows;
    reset = 1'b1;
    color = 6'b111111;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst_hold");
    chk_en = 1'b1;

    @(negedge clk);
    reset = 1'b0;
    color = 6'b110100;
    first_hs_low = 0; hs_lows = 0; first_vs_low = 0; vs_lows = 0;
    for (int e = 1; e <= 256 * FT; e++) begin
      @(posedge clk);
      #1;
      if (e <= HT && !hsync) begin
        hs_lows++;
        if (first_hs_low == 0) first_hs_low = e;
      end
      if (e <= FT && !vsync) begin
        vs_lows++;
        if (first_vs_low == 0) first_vs_low = e;
      end
      case (e)
        1:  chk("lit_rgb_first_pixel", 32'(rgb), 32'(6'b110100));
        12: chk("lit_rgb_last_visible", 32'(rgb), 32'(6'b110100));
        13: chk("lit_rgb_first_blank", 32'(rgb), 0);
        19: begin
          chk("lit_x_end", 32'(pix_x), 19);
          chk("lit_y_before_wrap", 32'(pix_y), 0);
        end
        20: begin
          chk("lit_x_wrap", 32'(pix_x), 0);
          chk("lit_y_step", 32'(pix_y), 1);
          chk("lit_hs_first_low_edge", 32'(first_hs_low), 15);
          chk("lit_hs_low_width", 32'(hs_lows), 3);
        end
        121: chk("lit_rgb_blank_line", 32'(rgb), 0);
        199: begin
          chk("lit_frame_before", 32'(frame), 0);
          chk("lit_y_end", 32'(pix_y), 9);
        end
        200: begin
          chk("lit_frame_step", 32'(frame), 1);
          chk("lit_frame_wrap_pos", 32'(pix_x + pix_y), 0);
          chk("lit_vs_first_low_edge", 32'(first_vs_low), 141);
          chk("lit_vs_low_width", 32'(vs_lows), 40);
        end
        255 * FT: chk("lit_frame_255", 32'(frame), 255);
        256 * FT: begin
          chk("lit_frame_rollover", 32'(frame), 0);
          chk("lit_rollover_x", 32'(pix_x), 0);
          chk("lit_rollover_y", 32'(pix_y), 0);
        end
        default: ;
      endcase
      if (e >= FT) color = 6'($urandom);
    end

    // Advance to frame 2, position (10,5), then reset between edges.
    color = 6'b101011;
    repeat (2 * FT + 5 * HT + 10) @(posedge clk);
    #1;
    chk("pre_rst_x", 32'(pix_x), 10);
    chk("pre_rst_y", 32'(pix_y), 5);
    chk("pre_rst_frame", 32'(frame), 2);
    chk("pre_rst_rgb", 32'(rgb), 32'(6'b101011));
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("async_rst");
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b0;
    first_hs_low = 0;
    for (int e = 1; e <= HT; e++) begin
      @(posedge clk);
      #1;
      if (!hsync && first_hs_low == 0) first_hs_low = e;
      if (e == 1) begin
        chk("resume_x", 32'(pix_x), 1);
        chk("resume_y", 32'(pix_y), 0);
      end
    end
    chk("resume_hs_first_low_edge", 32'(first_hs_low), 15);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
